// File: rtl/elevator_request_queue_if.sv
// Signal bundle between the call-button panel, the request queue and the
// downstream elevator state machine. The queue sits on the slave side. It
// receives buttons and car status, and it drives the target floor and status.
interface elevator_request_queue_if;
  logic [3:0] call_btn;
  logic [3:0] current_floor;
  logic       idle;
  logic [3:0] requested_floor;
  logic [3:0] pending;
  logic       door_open;
  logic       dir_up;

  modport master (
    output call_btn, current_floor, idle,
    input  requested_floor, pending, door_open, dir_up
  );

  modport slave (
    input  call_btn, current_floor, idle,
    output requested_floor, pending, door_open, dir_up
  );
endinterface

// File: rtl/elevator_request_queue.sv
// Elevator request queue using a SCAN scheduler.
// Button rising edges are latched into a pending bitmap. A three-state FSM
// picks the nearest pending floor in the current sweep direction. It also
// retargets to a closer floor that is called mid-travel, and it holds the
// door open for DWELL_COUNT cycles at each served floor.
module elevator_request_queue #(
  parameter logic [31:0] DWELL_COUNT = 32'd5000000
) (
  input  logic                     clk,
  input  logic                     rst,
  elevator_request_queue_if.slave  bus
);

  typedef enum logic [1:0] {
    SELECT = 2'd0,
    TRAVEL = 2'd1,
    DOOR   = 2'd2
  } state_t;

  localparam logic [31:0] DWELL_LAST = DWELL_COUNT - 32'd1;

  state_t      state;
  logic [3:0]  btn_prev;
  logic [3:0]  pending_q;
  logic [3:0]  requested_q;
  logic        door_q;
  logic        dir_up_q;
  logic [31:0] dwell_cnt;

  logic [3:0]  cur_bit;
  logic        cur_valid;
  logic        cur_hit;
  logic [3:0]  call_edge;
  logic [3:0]  ahead_up;
  logic [3:0]  ahead_dn;
  logic [3:0]  between_up;
  logic [3:0]  between_dn;
  logic        restart;
  logic        dwell_done;
  logic [3:0]  pending_d;

  // One-hot bit for a floor number. Floors outside 1..4 map to no bit.
  function automatic logic [3:0] floor_bit(input logic [3:0] f);
    floor_bit = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (4'(i + 1) == f) floor_bit[i] = 1'b1;
  endfunction

  // Mask of floors strictly above f.
  function automatic logic [3:0] above_mask(input logic [3:0] f);
    above_mask = 4'b0000;
    for (int i = 0; i < 4; i++)
      above_mask[i] = (4'(i + 1) > f);
  endfunction

  // Mask of floors strictly below f.
  function automatic logic [3:0] below_mask(input logic [3:0] f);
    below_mask = 4'b0000;
    for (int i = 0; i < 4; i++)
      below_mask[i] = (4'(i + 1) < f);
  endfunction

  // Lowest floor whose bit is set. Callers only pass non-empty masks.
  function automatic logic [3:0] lowest_floor(input logic [3:0] m);
    lowest_floor = 4'd1;
    for (int i = 3; i >= 0; i--)
      if (m[i]) lowest_floor = 4'(i + 1);
  endfunction

  // Highest floor whose bit is set. Callers only pass non-empty masks.
  function automatic logic [3:0] highest_floor(input logic [3:0] m);
    highest_floor = 4'd1;
    for (int i = 0; i < 4; i++)
      if (m[i]) highest_floor = 4'(i + 1);
  endfunction

  // Call detection, direction masks and the next pending bitmap.
  always_comb begin
    // NOTE: every signal gets a value on every path here; otherwise synthesis infers a latch.
    cur_bit    = floor_bit(bus.current_floor);
    cur_valid  = |cur_bit;
    cur_hit    = |(pending_q & cur_bit);
    call_edge  = bus.call_btn & ~btn_prev;
    ahead_up   = pending_q & above_mask(bus.current_floor);
    ahead_dn   = pending_q & below_mask(bus.current_floor);
    between_up = ahead_up & below_mask(requested_q);
    between_dn = ahead_dn & above_mask(requested_q);
    // A fresh call at the floor being served re-opens the dwell and keeps the bit set.
    restart    = (state == DOOR) && |(call_edge & cur_bit);
    dwell_done = (state == DOOR) && !restart && (dwell_cnt == DWELL_LAST);
    pending_d  = (pending_q | call_edge) & ~(dwell_done ? cur_bit : 4'b0000);
  end

  // Scheduler FSM with the button history, pending bitmap and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: only control state lives here, so every register gets a reset value.
      state       <= SELECT;
      btn_prev    <= 4'b0000;
      pending_q   <= 4'b0000;
      requested_q <= 4'd1;
      door_q      <= 1'b0;
      dir_up_q    <= 1'b1;
      dwell_cnt   <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments, so every branch sees the pre-edge register values.
      btn_prev  <= bus.call_btn;
      pending_q <= pending_d;
      case (state)
        SELECT: begin
          if (pending_q == 4'b0000) begin
            if (cur_valid) requested_q <= bus.current_floor;
          end else if (cur_hit && bus.idle) begin
            state     <= DOOR;
            door_q    <= 1'b1;
            dwell_cnt <= 32'd0;
          end else begin
            if (dir_up_q) begin
              if (|ahead_up) begin
                requested_q <= lowest_floor(ahead_up);
              end else begin
                dir_up_q    <= 1'b0;
                requested_q <= highest_floor(pending_q);
              end
            end else begin
              if (|ahead_dn) begin
                requested_q <= highest_floor(ahead_dn);
              end else begin
                dir_up_q    <= 1'b1;
                requested_q <= lowest_floor(pending_q);
              end
            end
            state <= TRAVEL;
          end
        end
        TRAVEL: begin
          if (bus.idle && (bus.current_floor == requested_q)) begin
            state     <= DOOR;
            door_q    <= 1'b1;
            dwell_cnt <= 32'd0;
          end else if (dir_up_q && |between_up) begin
            requested_q <= lowest_floor(between_up);
          end else if (!dir_up_q && |between_dn) begin
            requested_q <= highest_floor(between_dn);
          end
        end
        DOOR: begin
          if (restart) begin
            dwell_cnt <= 32'd0;
          end else if (dwell_cnt == DWELL_LAST) begin
            door_q    <= 1'b0;
            dwell_cnt <= 32'd0;
            state     <= SELECT;
          end else begin
            dwell_cnt <= dwell_cnt + 32'd1;
          end
        end
        default: state <= SELECT;
      endcase
    end
  end

  assign bus.requested_floor = requested_q;
  assign bus.pending         = pending_q;
  assign bus.door_open       = door_q;
  assign bus.dir_up          = dir_up_q;

endmodule

// File: tb/tb_elevator_request_queue.sv
// Directed bench for elevator_request_queue with a 4-cycle dwell.
// Inputs change 1 ns after a rising edge, and outputs are sampled at that point.
module tb_elevator_request_queue;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  elevator_request_queue_if bus ();

  elevator_request_queue #(.DWELL_COUNT(32'd4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call this right after the edge that enters DOOR. The door should be high
  // for exactly four samples and then drop.
  task automatic door_cycle(input string tag);
    check({tag, "_door0"}, 32'(bus.door_open), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check({tag, "_door_hi"}, 32'(bus.door_open), 32'd1);
    end
    step();
    check({tag, "_door_lo"}, 32'(bus.door_open), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.call_btn      = 4'b0000;
    bus.current_floor = 4'd1;
    bus.idle          = 1'b1;
    #3;
    check("rst_req",     32'(bus.requested_floor), 32'd1);
    check("rst_pending", 32'(bus.pending),         32'd0);
    check("rst_door",    32'(bus.door_open),       32'd0);
    check("rst_dir",     32'(bus.dir_up),          32'd1);
    step();
    rst = 1'b0;

    // Floor 1 calls floor 3: pending after 1 cycle, target after 2 cycles.
    bus.call_btn = 4'b0100;
    step();
    bus.call_btn = 4'b0000;
    check("a_pending", 32'(bus.pending),         32'h4);
    check("a_req1",    32'(bus.requested_floor), 32'd1);
    step();
    check("a_req3",    32'(bus.requested_floor), 32'd3);
    check("a_dir",     32'(bus.dir_up),          32'd1);
    bus.idle = 1'b0;
    bus.current_floor = 4'd2;
    step();
    bus.current_floor = 4'd3;
    bus.idle = 1'b1;
    step();
    door_cycle("a");
    check("a_cleared", 32'(bus.pending), 32'd0);

    // At floor 3 going up, only floor 1 is pending, so the direction reverses.
    bus.call_btn = 4'b0001;
    step();
    bus.call_btn = 4'b0000;
    step();
    check("c_dir", 32'(bus.dir_up),          32'd0);
    check("c_req", 32'(bus.requested_floor), 32'd1);
    bus.current_floor = 4'd1;
    step();
    door_cycle("c");
    check("c_cleared", 32'(bus.pending), 32'd0);

    // Heading for 4 from floor 1, a call at floor 2 retargets mid-travel.
    bus.call_btn = 4'b1000;
    step();
    bus.call_btn = 4'b0000;
    step();
    check("b_req4", 32'(bus.requested_floor), 32'd4);
    check("b_dir",  32'(bus.dir_up),          32'd1);
    bus.idle = 1'b0;
    bus.call_btn = 4'b0010;
    step();
    bus.call_btn = 4'b0000;
    check("b_pend", 32'(bus.pending),         32'ha);
    check("b_req4b", 32'(bus.requested_floor), 32'd4);
    step();
    check("b_req2", 32'(bus.requested_floor), 32'd2);
    bus.current_floor = 4'd2;
    bus.idle = 1'b1;
    step();
    door_cycle("b");
    check("b_pend_after", 32'(bus.pending), 32'h8);
    step();
    check("b_req_next", 32'(bus.requested_floor), 32'd4);
    bus.current_floor = 4'd4;
    step();
    door_cycle("b4");
    check("b4_cleared", 32'(bus.pending), 32'd0);

    // Door at floor 2: a re-press at dwell count 2 restarts the dwell.
    bus.call_btn = 4'b0010;
    step();
    bus.call_btn = 4'b0000;
    step();
    check("d_dir", 32'(bus.dir_up),          32'd0);
    check("d_req", 32'(bus.requested_floor), 32'd2);
    bus.current_floor = 4'd2;
    step();
    check("d_door_e0", 32'(bus.door_open), 32'd1);
    step();
    step();
    bus.call_btn = 4'b0010;
    step();
    bus.call_btn = 4'b0000;
    check("d_door_restart", 32'(bus.door_open), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("d_door_ext", 32'(bus.door_open), 32'd1);
    end
    check("d_pend_held", 32'(bus.pending), 32'h2);
    step();
    check("d_door_lo",   32'(bus.door_open), 32'd0);
    check("d_pend_clr",  32'(bus.pending),   32'd0);

    // Holding floor 4 for 10 cycles gives one call, served once and not re-latched.
    bus.call_btn = 4'b1000;
    step();
    check("e_pend_set", 32'(bus.pending), 32'h8);
    step();
    check("e_req4", 32'(bus.requested_floor), 32'd4);
    bus.current_floor = 4'd4;
    step();
    check("e_door", 32'(bus.door_open), 32'd1);
    for (int i = 0; i < 4; i++) step();
    check("e_pend_served", 32'(bus.pending), 32'd0);
    for (int i = 0; i < 3; i++) step();
    check("e_pend_hold", 32'(bus.pending), 32'd0);
    bus.call_btn = 4'b0000;
    step();
    bus.call_btn = 4'b1000;
    step();
    check("e_repress", 32'(bus.pending), 32'h8);
    step();
    check("e_direct_door", 32'(bus.door_open),       32'd1);
    check("e_direct_req",  32'(bus.requested_floor), 32'd4);
    step();
    #2;
    rst = 1'b1;
    #1;
    check("r_pending", 32'(bus.pending),         32'd0);
    check("r_door",    32'(bus.door_open),       32'd0);
    check("r_req",     32'(bus.requested_floor), 32'd1);
    check("r_dir",     32'(bus.dir_up),          32'd1);

    // Button held through reset release at an invalid floor 0: the call
    // latches but the door never opens.
    bus.call_btn = 4'b0001;
    bus.current_floor = 4'd0;
    bus.idle = 1'b1;
    step();
    check("r_pend_in_rst", 32'(bus.pending), 32'd0);
    rst = 1'b0;
    step();
    check("f_pend", 32'(bus.pending),         32'h1);
    check("f_req1", 32'(bus.requested_floor), 32'd1);
    bus.call_btn = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step();
      check("f_no_door", 32'(bus.door_open),       32'd0);
      check("f_req",     32'(bus.requested_floor), 32'd1);
    end
    check("f_pend_kept", 32'(bus.pending), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_request_queue.md
ELEVATOR_REQUEST_QUEUE -- requirements
Module: elevator_request_queue

Interface
REQ-001 SHALL have parameter DWELL_COUNT, default 32'd5000000, door-open dwell length in clk cycles (benches override to 4).
REQ-002 SHALL have ports: clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 call_btn  input  4  level call buttons, bit0=floor 1 ... bit3=floor 4.
REQ-005 current_floor  input  4  floor reported by the downstream elevator state machine, valid range 1..4.
REQ-006 idle  input  1  high when the downstream state machine is idle (not moving).
REQ-007 requested_floor  output  4  registered target floor driven to the downstream state machine, always in 1..4.
REQ-008 pending  output  4  registered outstanding-call bitmap, same bit mapping as call_btn.
REQ-009 door_open  output  1  registered, high during dwell at a served floor.
REQ-010 dir_up  output  1  registered scan direction, 1=up, 0=down.

Function
REQ-011 SHALL register call_btn into btn_prev each cycle; a call is a rising edge (call_btn & ~btn_prev) and sets the matching pending bit next cycle.
REQ-012 Holding a button SHALL register one call only; re-press after release SHALL register again.
REQ-013 SHALL implement FSM states SELECT, TRAVEL, DOOR.
REQ-014 SELECT, pending==0: stay; requested_floor <= current_floor if in 1..4, else hold.
REQ-015 SELECT, pending!=0, bit of current_floor set and idle=1: go DOOR directly, requested_floor unchanged.
REQ-016 SELECT otherwise: if any pending floor strictly ahead in dir_up direction, target = nearest such; else toggle dir_up and target = nearest pending floor in new direction; register target into requested_floor, go TRAVEL.
REQ-017 TRAVEL: if a new pending floor lies strictly between current_floor and requested_floor in dir_up direction, requested_floor SHALL update to the nearest such floor next cycle.
REQ-018 TRAVEL: when idle=1 and current_floor==requested_floor, go DOOR.
REQ-019 DOOR: door_open=1, dwell counter counts 0..DWELL_COUNT-1; on reaching DWELL_COUNT-1 clear pending bit of current_floor, door_open <= 0, counter <= 0, go SELECT.
REQ-020 DOOR: new call at current_floor SHALL restart dwell counter to 0 and leave the bit to be cleared at dwell end.
REQ-021 Same-cycle set of one pending bit and clear of another SHALL both take effect; same-cycle set and clear of the same bit: clear wins unless REQ-020 restart applies (then no clear).
REQ-022 current_floor outside 1..4 SHALL never match a pending bit; requested_floor SHALL stay in 1..4.
REQ-023 Total: call edge to requested_floor update SHALL be 2 cycles when FSM is in SELECT (1 to pending, 1 to target).
REQ-024 All comparisons unsigned 4-bit; no arithmetic wraps below 1 or above 4.

Reset
REQ-025 While rst high: state=SELECT, pending=4'b0000, btn_prev=4'b0000, requested_floor=4'd1, door_open=0, dir_up=1, dwell counter=0.
REQ-026 Reset mid-DOOR or mid-TRAVEL SHALL discard all pending calls and dwell progress immediately (asynchronous).
REQ-027 A button held through reset release SHALL register as one call on the first clock after release.

Verification (DWELL_COUNT=4)
REQ-028 Reset, current_floor=1, idle=1, pulse call_btn=4'b0100 -> pending=4'b0100 after 1 cycle, requested_floor=3, dir_up=1 after 2 cycles.
REQ-029 Target 4 in TRAVEL at floor 1, press floor 2 -> requested_floor becomes 2; on idle=1 at floor 2, door_open high 4 cycles, pending bit1 cleared, then target 4.
REQ-030 At floor 3 dir_up=1, pending=4'b0001 only -> dir_up becomes 0, requested_floor=1.
REQ-031 In DOOR at floor 2, re-press floor 2 at dwell count 2 -> door_open stays high 4 further cycles, bit1 cleared once.
REQ-032 Hold call_btn[3] 10 cycles -> single pending set; assert rst mid-DOOR -> pending=0, door_open=0, requested_floor=1 without clock edge.
REQ-033 current_floor=4'd0 with pending=4'b0001, idle=1 -> no DOOR entry, requested_floor stays 1.
